imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Owns the single instruction-memory port and shares it between two users: a boot loader that writes program words, and the core's fetch path, which reads one instruction per cycle. It holds the PC and applies stall and branch redirects. It detects ECALL to halt the core and counts retired instructions. It sits between the program loader, the single-cycle core and the instruction memory, whose write port is added alongside the existing combinational read.

Parameters:
ADDR_SIZE, 8, IMEM word-address width; depth = 2**ADDR_SIZE words
INST_SIZE, 32, instruction width
RESET_PC, 32'h0000_0000, byte address loaded into the PC on RUN entry
ECALL_WORD, 32'h0000_0073, encoding that triggers HALT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
load_en  in  1  IDLE/HALT -> LOAD request
run_en  in  1  IDLE/HALT -> RUN request (load_en has priority)
load_valid  in  1  loader word valid
load_ready  out  1  controller accepts loader word
load_data  in  INST_SIZE  loader word
load_last  in  1  final word of the image
imem_we  out  1  IMEM write enable
imem_waddr  out  ADDR_SIZE  IMEM write word address
imem_wdata  out  INST_SIZE  IMEM write data
imem_addr  out  ADDR_SIZE  IMEM read word address
imem_rdata  in  INST_SIZE  IMEM read data (combinational)
stall  in  1  core hold request
branch_taken  in  1  redirect request
branch_target  in  32  redirect byte address
pc_out  out  32  current PC (byte address)
instr_out  out  INST_SIZE  fetched instruction
instr_valid  out  1  instr_out is to be executed this cycle
halted  out  1  controller is in HALT
load_words  out  ADDR_SIZE+1  word count of the last completed load
instr_count  out  32  retired instruction count

Behaviour:
- Reset values: state=IDLE; pc=RESET_PC; waddr counter=0; load_words=0; instr_count=0. All outputs are 0 except pc_out=RESET_PC. Reset mid-load or mid-run aborts immediately; IMEM contents are not this block's concern.
- State machine: IDLE, LOAD, RUN, HALT.
- IDLE/HALT: load_en -> LOAD with waddr=0. Otherwise run_en -> RUN with pc=RESET_PC and instr_count=0.
- LOAD: load_ready=1. A word is accepted when load_valid&load_ready. On acceptance: imem_we=1 (combinational), imem_waddr=counter, imem_wdata=load_data, then counter++.
- LOAD exit: on the accepted word with load_last=1, or on the word written at address 2**ADDR_SIZE-1. Next state is IDLE; load_words=accepted count, range 1..2**ADDR_SIZE; counter returns to 0. Extra loader words are not accepted (load_ready=0). A load with zero words stays in LOAD.
- RUN read path: imem_addr=pc[ADDR_SIZE+1:2]; instr_out=imem_rdata. instr_valid=1 while in RUN and stall=0. Zero latency: address and data in the same cycle. pc_out=pc.
- RUN PC update at each edge, in priority order:
  - stall=1: hold the PC. A simultaneous branch_taken is ignored; the core re-asserts it.
  - branch_taken=1: pc = {branch_target[31:2],2'b00} (low bits forced to zero).
  - else: pc = pc+4, wrapping modulo 2**32. The IMEM index wraps naturally modulo depth.
- instr_count increments on every cycle with instr_valid=1, saturating at 32'hFFFF_FFFF.
- ECALL: instr_valid=1 and instr_out==ECALL_WORD -> HALT next cycle. The ECALL itself is counted. A branch in the same cycle is ignored. PC holds the ECALL address.
- HALT: halted=1, instr_valid=0; pc and instr_count frozen; exits as IDLE.
- In IDLE, LOAD and HALT: imem_addr=0, instr_out=0, instr_valid=0.
- IMEM write and read never overlap, because they are used in disjoint states.

Decomposition:
- Shared package imem_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} fetch_state_t
  - localparam ECALL_WORD
  - the PC increment constant 4
- One sub-module, pc_sequencer: holds the PC register and applies the stall/branch/increment priority. It has an enable and a load-RESET_PC input. The FSM, loader counter and instruction counter stay at top level.

Test Plan:
- Reset then load_en; stream 0x00100093, 0x00200113, 0x00208433 with load_last on the third -> imem_we at waddr 0,1,2; state IDLE; load_words=3.
- Stream 256 words with no load_last -> write at waddr 255, then IDLE; load_words=256; load_ready=0 afterwards.
- run_en on the loaded image -> pc_out 0,4,8 on consecutive cycles; imem_addr 0,1,2; instr_count=3 after three cycles.
- In RUN at pc=8: stall=1 with branch_taken=1 and target 0x40 for 2 cycles -> pc stays 8 and instr_valid=0. Then branch_taken alone with target 0x43 -> pc=0x40.
- Image whose word 2 is 0x00000073 -> ECALL is presented valid at pc=8; halted=1 next cycle; pc frozen at 8; instr_count=3.
- Assert reset mid-LOAD after 5 words, then mid-RUN -> all outputs return to reset values within the same cycle, independent of clk. A subsequent run_en restarts at pc 0.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
    localparam logic [31:0] PC_INCR    = 32'd4;

endpackage : imem_ctrl_pkg

// File: rtl/pc_sequencer.sv
// Program counter register: restart to RESET_PC, else stall > branch > +4 while advancing.
module pc_sequencer
    import imem_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart_i,
    input  logic        advance_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        // NOTE: pc_d takes a default before any branch so no path can leave it unassigned and infer a latch.
        pc_d = pc_q;
        if (restart_i) begin
            pc_d = RESET_PC;
        end else if (advance_i && !stall_i) begin
            if (branch_taken_i) begin
                pc_d = branch_target_i & 32'hFFFF_FFFC;
            end else begin
                pc_d = pc_q + PC_INCR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : pc_sequencer

// File: rtl/imem_fetch_ctrl.sv
// Shares one IMEM port between the boot loader (writes) and the core fetch path (reads);
// owns the run/halt FSM, the loader address counter and the retired-instruction counter.
module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned INST_SIZE = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic                 run_en,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [INST_SIZE-1:0] load_data,
    input  logic                 load_last,
    output logic                 imem_we,
    output logic [ADDR_SIZE-1:0] imem_waddr,
    output logic [INST_SIZE-1:0] imem_wdata,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic [INST_SIZE-1:0] imem_rdata,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic [31:0]          pc_out,
    output logic [INST_SIZE-1:0] instr_out,
    output logic                 instr_valid,
    output logic                 halted,
    output logic [ADDR_SIZE:0]   load_words,
    output logic [31:0]          instr_count
);

    fetch_state_t         state_q;
    logic [ADDR_SIZE-1:0] waddr_q;
    logic [ADDR_SIZE:0]   load_words_q;
    logic [31:0]          instr_count_q;
    logic [31:0]          pc;

    logic in_run;
    logic can_start;
    logic start_load;
    logic start_run;
    logic accept;
    logic load_done;
    logic ecall;

    assign in_run     = (state_q == RUN);
    assign can_start  = (state_q == IDLE) || (state_q == HALT);
    assign start_load = can_start && load_en;
    assign start_run  = can_start && !load_en && run_en;

    assign load_ready = (state_q == LOAD);
    assign accept     = load_ready && load_valid;
    assign load_done  = accept && (load_last || (waddr_q == '1));

    // Write side is only live in LOAD, read side only in RUN, so the port is never contended.
    assign imem_we     = accept;
    assign imem_waddr  = accept ? waddr_q : '0;
    assign imem_wdata  = accept ? load_data : '0;
    assign imem_addr   = in_run ? pc[ADDR_SIZE+1:2] : '0;
    assign instr_out   = in_run ? imem_rdata : '0;
    assign instr_valid = in_run && !stall;
    assign ecall       = instr_valid && (instr_out == INST_SIZE'(ECALL_WORD));

    assign halted      = (state_q == HALT);
    assign load_words  = load_words_q;
    assign instr_count = instr_count_q;
    assign pc_out      = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            load_words_q <= '0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start_load) begin
                        state_q <= LOAD;
                        waddr_q <= '0;
                    end else if (start_run) begin
                        state_q <= RUN;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        state_q      <= IDLE;
                        load_words_q <= {1'b0, waddr_q} + (ADDR_SIZE+1)'(1);
                        waddr_q      <= '0;
                    end else if (accept) begin
                        waddr_q <= waddr_q + ADDR_SIZE'(1);
                    end
                end
                RUN: begin
                    if (ecall) begin
                        state_q <= HALT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_q <= '0;
        end else if (start_run) begin
            instr_count_q <= '0;
        end else if (instr_valid && (instr_count_q != 32'hFFFF_FFFF)) begin
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    // ECALL freezes the PC on its own address; HALT then keeps it frozen.
    pc_sequencer #(
        .RESET_PC (RESET_PC)
    ) u_pc_sequencer (
        .clk             (clk),
        .reset           (reset),
        .restart_i       (start_run),
        .advance_i       (in_run && !ecall),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_o            (pc)
    );

endmodule : imem_fetch_ctrl

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a behavioural controller model plus a bench-owned IMEM,
// compared every falling edge, with literal expectations at the directed test points.
module tb_imem_fetch_ctrl;

    localparam int          AW       = 8;
    localparam int          IW       = 32;
    localparam int          DEPTH    = 256;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic          clk;
    logic          reset;
    logic          load_en;
    logic          run_en;
    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [IW-1:0] imem_wdata;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          stall;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   pc_out;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          halted;
    logic [AW:0]   load_words;
    logic [31:0]   instr_count;

    imem_fetch_ctrl #(
        .ADDR_SIZE (AW),
        .INST_SIZE (IW),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .run_en        (run_en),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .load_words    (load_words),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-owned instruction memory: written only through the DUT's write port.
    logic [IW-1:0] mem [DEPTH];
    assign imem_rdata = mem[imem_addr];
    always @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the image the loader should have placed, and the controller's visible state.
    logic [31:0] ref_img [DEPTH];
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_wptr;
    int          m_words;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = RESET_PC;
        m_cnt   = 0;
        m_wptr  = 0;
        m_words = 0;
    endtask

    function automatic int cur_index();
        return int'((m_pc >> 2) % DEPTH);
    endfunction

    task automatic compare_all();
        bit acc;
        acc = (m_mode == M_LOAD) && load_valid;
        check("load_ready",  load_ready,  m_mode == M_LOAD);
        check("imem_we",     imem_we,     acc);
        check("imem_waddr",  imem_waddr,  acc ? m_wptr : 0);
        check("imem_wdata",  imem_wdata,  acc ? load_data : 0);
        check("imem_addr",   imem_addr,   (m_mode == M_RUN) ? cur_index() : 0);
        check("instr_out",   instr_out,   (m_mode == M_RUN) ? ref_img[cur_index()] : 0);
        check("instr_valid", instr_valid, (m_mode == M_RUN) && !stall);
        check("halted",      halted,      m_mode == M_HALT);
        check("pc_out",      pc_out,      m_pc);
        check("load_words",  load_words,  m_words);
        check("instr_count", instr_count, m_cnt);
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE, M_HALT: begin
                if (load_en) begin
                    m_mode = M_LOAD;
                    m_wptr = 0;
                end else if (run_en) begin
                    m_mode = M_RUN;
                    m_pc   = RESET_PC;
                    m_cnt  = 0;
                end
            end
            M_LOAD: begin
                if (load_valid) begin
                    ref_img[m_wptr] = load_data;
                    if (load_last || m_wptr == DEPTH - 1) begin
                        m_words = m_wptr + 1;
                        m_wptr  = 0;
                        m_mode  = M_IDLE;
                    end else begin
                        m_wptr++;
                    end
                end
            end
            M_RUN: begin
                if (!stall) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                    if (ref_img[cur_index()] == ECALL) m_mode = M_HALT;
                    else if (branch_taken)             m_pc = branch_target & 32'hFFFF_FFFC;
                    else                               m_pc = m_pc + 32'd4;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) model_reset();
        compare_all();
        if (!reset) model_step();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic start_run();
        run_en = 1'b1;
        cyc();
        run_en = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, input int exp_addr);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        @(negedge clk);
        check("lit_we", imem_we, 1);
        check("lit_waddr", imem_waddr, exp_addr);
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1;
        check("rst_pc",        pc_out,      RESET_PC);
        check("rst_valid",     instr_valid, 0);
        check("rst_count",     instr_count, 0);
        check("rst_addr",      imem_addr,   0);
        check("rst_instr",     instr_out,   0);
        check("rst_halted",    halted,      0);
        check("rst_words",     load_words,  0);
        check("rst_ready",     load_ready,  0);
        check("rst_we",        imem_we,     0);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] prog_a [3];
    logic [31:0] prog_e [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_img[i] = '0;
        end
        model_reset();
        prog_a = '{32'h0010_0093, 32'h0020_0113, 32'h0020_8433};
        prog_e = '{32'h0010_0093, 32'h0020_0113, 32'h0000_0073, 32'h0020_8433};

        reset = 1'b1; load_en = 0; run_en = 0; load_valid = 0; load_data = '0;
        load_last = 0; stall = 0; branch_taken = 0; branch_target = '0;
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clk);
        check("lit_reset_pc", pc_out, 32'h0);
        check("lit_reset_words", load_words, 0);
        cyc();

        // Three-word image terminated by load_last.
        start_load();
        for (int i = 0; i < 3; i++) send_word(prog_a[i], i == 2, i);
        @(negedge clk);
        check("lit_words3", load_words, 3);
        check("lit_idle_ready", load_ready, 0);
        cyc();

        // Full-depth image without load_last: ends on address 255.
        start_load();
        for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + i, 1'b0, i);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lit_words256", load_words, 256);
        check("lit_full_ready", load_ready, 0);
        check("lit_full_we", imem_we, 0);
        cyc();
        load_valid = 1'b0;

        // Sequential fetch, then stall with a competing branch, then branch with unaligned target.
        start_run();
        @(negedge clk);
        check("lit_pc0", pc_out, 32'h0);
        check("lit_addr0", imem_addr, 0);
        check("lit_instr0", instr_out, 32'h1000_0000);
        cyc();
        @(negedge clk);
        check("lit_pc4", pc_out, 32'h4);
        check("lit_addr1", imem_addr, 1);
        cyc();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        check("lit_pc8", pc_out, 32'h8);
        check("lit_addr2", imem_addr, 2);
        check("lit_stall_valid", instr_valid, 0);
        check("lit_count2", instr_count, 2);
        cyc();
        @(negedge clk);
        check("lit_stall_pc", pc_out, 32'h8);
        cyc();
        stall = 1'b0; branch_target = 32'h43;
        @(negedge clk);
        check("lit_branch_valid", instr_valid, 1);
        cyc();
        branch_taken = 1'b0;
        @(negedge clk);
        check("lit_pc40", pc_out, 32'h40);
        check("lit_count3", instr_count, 3);
        check("lit_instr16", instr_out, 32'h1000_0010);
        cyc(); cyc();

        // Reset in the middle of RUN.
        async_reset_check();
        cyc();

        // Reset in the middle of LOAD, after five accepted words.
        start_load();
        for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + i, 1'b0, i);
        check("lit_midload_ready", load_ready, 1);
        async_reset_check();
        cyc();

        // Image with ECALL at word 2; a branch alongside the ECALL is ignored.
        start_load();
        for (int i = 0; i < 4; i++) send_word(prog_e[i], i == 3, i);
        @(negedge clk);
        check("lit_words4", load_words, 4);
        cyc();
        start_run();
        @(negedge clk);
        check("lit_e_pc0", pc_out, 32'h0);
        check("lit_e_instr0", instr_out, 32'h0010_0093);
        cyc(); cyc();
        branch_taken = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        check("lit_ecall_instr", instr_out, ECALL);
        check("lit_ecall_valid", instr_valid, 1);
        check("lit_ecall_pc", pc_out, 32'h8);
        cyc();
        branch_taken = 1'b0;
        @(negedge clk);
        check("lit_halted", halted, 1);
        check("lit_halt_pc", pc_out, 32'h8);
        check("lit_halt_count", instr_count, 3);
        check("lit_halt_valid", instr_valid, 0);
        cyc(); cyc();
        @(negedge clk);
        check("lit_frozen_pc", pc_out, 32'h8);
        check("lit_frozen_count", instr_count, 3);
        cyc();

        // HALT -> RUN restarts from RESET_PC with a cleared count.
        start_run();
        @(negedge clk);
        check("lit_restart_pc", pc_out, 32'h0);
        check("lit_restart_count", instr_count, 0);
        check("lit_restart_halted", halted, 0);
        cyc();
        @(negedge clk);
        check("lit_restart_count1", instr_count, 1);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_imem_fetch_ctrl
